// File: rtl/cp0_int_ctrl.sv
// Coprocessor-0 interrupt/exception controller: masks six level-sensitive IRQ lines,
// raises one exception request to the pipeline and holds SR/Cause/EPC for mfc0/mtc0.
module cp0_int_ctrl #(
  parameter logic [31:0] PRID       = 32'h0000_4D49,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] DOut,
  output logic [31:0] Handler
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [29:0] epc_q, epc_d;

  logic        int_pend;
  logic        exc_pend;
  logic        int_req;
  logic [31:0] pc_ret;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic [31:0] epc_word;
  logic        unused_pc_bits;

  // An instruction in a delay slot restarts at its branch, one word earlier.
  always_comb begin
    int_pend = (|(HWInt & im_q)) & ie_q & ~exl_q;
    exc_pend = (ExcCodeIn != 5'd0) & ~exl_q;
    int_req  = int_pend | exc_pend;
    pc_ret   = BD ? (PC - 32'd4) : PC;
  end

  assign unused_pc_bits = ^pc_ret[1:0];

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = HWInt;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (int_req) begin
      exl_d      = 1'b1;
      bd_d       = BD;
      exc_code_d = int_pend ? 5'd0 : ExcCodeIn;
      epc_d      = pc_ret[31:2];
    end else if (EXLClr) begin
      exl_d = 1'b0;
    end else if (WE) begin
      case (A2)
        REG_SR: begin
          im_d  = DIn[15:10];
          exl_d = DIn[1];
          ie_d  = DIn[0];
        end
        REG_EPC: epc_d = DIn[31:2];
        default: ;
      endcase
    end else begin
      exl_d = exl_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 30'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // Reads see the pre-edge register contents; no write bypass.
  always_comb begin
    sr_word    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    cause_word = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
    epc_word   = {epc_q, 2'b00};
    case (A1)
      REG_SR:    DOut = sr_word;
      REG_CAUSE: DOut = cause_word;
      REG_EPC:   DOut = epc_word;
      REG_PRID:  DOut = PRID;
      default:   DOut = 32'd0;
    endcase
  end

  assign IntReq  = int_req;
  assign EPC     = epc_word;
  assign Handler = HANDLER_PC;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Bench for cp0_int_ctrl: directed scenarios followed by random traffic, all checked
// against a word-level model of SR/Cause/EPC.
module tb_cp0_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, ExcCodeIn;
  logic [31:0] DIn, PC;
  logic        WE, BD, EXLClr;
  logic [5:0]  HWInt;
  logic        IntReq;
  logic [31:0] EPC, DOut, Handler;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sr_m, cause_m, epc_m;

  cp0_int_ctrl dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE), .PC(PC), .BD(BD),
    .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
    .IntReq(IntReq), .EPC(EPC), .DOut(DOut), .Handler(Handler)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return sr_m;
      5'd13:   return cause_m;
      5'd14:   return epc_m;
      5'd15:   return 32'h0000_4D49;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    logic        ip, ep, req;
    logic [31:0] cn;
    @(negedge clk);
    ip  = ((HWInt & sr_m[15:10]) != 6'd0) && sr_m[0] && !sr_m[1];
    ep  = (ExcCodeIn != 5'd0) && !sr_m[1];
    req = ip || ep;
    chk("intreq", {31'd0, IntReq}, {31'd0, req});
    chk("dout", DOut, model_read(A1));
    chk("epc", EPC, epc_m);
    chk("handler", Handler, 32'h0000_4180);
    if (reset) begin
      sr_m = 32'd0; cause_m = 32'd0; epc_m = 32'd0;
    end else begin
      cn = {16'd0, HWInt, 10'd0};
      if (req) begin
        sr_m    = sr_m | 32'h2;
        cause_m = cn | ({31'd0, BD} << 31) | ({27'd0, (ip ? 5'd0 : ExcCodeIn)} << 2);
        epc_m   = (BD ? PC - 32'd4 : PC) & 32'hFFFF_FFFC;
      end else begin
        cause_m = cn | (cause_m & 32'h8000_007C);
        if (EXLClr) sr_m = sr_m & ~32'h2;
        else if (WE && A2 == 5'd12) sr_m = DIn & 32'h0000_FC03;
        else if (WE && A2 == 5'd14) epc_m = DIn & 32'hFFFF_FFFC;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; WE = 1'b0; A2 = 5'd0; DIn = 32'd0; ExcCodeIn = 5'd0;
    EXLClr = 1'b0; BD = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    idle(); HWInt = 6'd0; WE = 1'b1; A2 = r; DIn = d;
    cycle();
    idle();
  endtask

  initial begin
    sr_m = 32'hx; cause_m = 32'hx; epc_m = 32'hx;
    idle(); A1 = 5'd13; PC = 32'h0000_3000; HWInt = 6'b000001;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    #2 chk("reset_cause_ip", DOut, 32'h0000_0400);
    A1 = 5'd12;
    #1 chk("reset_sr", DOut, 32'd0);
    chk("reset_intreq", {31'd0, IntReq}, 32'd0);
    cycle();

    // Interrupt entry from a non-delay-slot instruction
    mtc0(5'd12, 32'h0000_0401);
    HWInt = 6'b000001; PC = 32'h0000_3010; BD = 1'b0;
    #2 chk("irq_same_cycle", {31'd0, IntReq}, 32'd1);
    cycle();
    A1 = 5'd12;
    #2 chk("entry_sr", DOut, 32'h0000_0403);
    chk("entry_epc", EPC, 32'h0000_3010);
    chk("entry_intreq_drop", {31'd0, IntReq}, 32'd0);
    A1 = 5'd13;
    #1 chk("entry_exccode", {27'd0, DOut[6:2]}, 32'd0);
    cycle();

    // Delay-slot entry
    mtc0(5'd12, 32'h0000_0401);
    HWInt = 6'b000001; PC = 32'h0000_3014; BD = 1'b1;
    cycle();
    BD = 1'b0; A1 = 5'd13;
    #2 chk("bd_epc", EPC, 32'h0000_3010);
    chk("bd_cause31", {31'd0, DOut[31]}, 32'd1);

    // Interrupt beats internal exception; masked interrupt lets it through
    mtc0(5'd12, 32'h0000_0801);
    HWInt = 6'b000010; ExcCodeIn = 5'd12;
    cycle();
    A1 = 5'd13; ExcCodeIn = 5'd0;
    #2 chk("prio_int_wins", {27'd0, DOut[6:2]}, 32'd0);
    mtc0(5'd12, 32'h0000_0001);
    HWInt = 6'b000010; ExcCodeIn = 5'd12;
    cycle();
    ExcCodeIn = 5'd0; A1 = 5'd13;
    #2 chk("prio_exc_masked", {27'd0, DOut[6:2]}, 32'd12);

    // eret with a still-pending unmasked line re-enters immediately
    mtc0(5'd12, 32'h0000_0403);
    HWInt = 6'b000001; PC = 32'h0000_5000; EXLClr = 1'b1;
    #2 chk("eret_cycle_intreq", {31'd0, IntReq}, 32'd0);
    cycle();
    EXLClr = 1'b0; PC = 32'h0000_5008; A1 = 5'd12;
    #2 chk("eret_exl_clear", DOut, 32'h0000_0401);
    chk("eret_reentry", {31'd0, IntReq}, 32'd1);
    cycle();
    #2 chk("eret_epc", EPC, 32'h0000_5008);

    // mtc0 EPC lost to a simultaneous entry; PrID is read-only
    idle(); HWInt = 6'd0; EXLClr = 1'b1;
    cycle();
    idle(); HWInt = 6'b000001; PC = 32'h0000_6000;
    WE = 1'b1; A2 = 5'd14; DIn = 32'h1234_5677;
    cycle();
    #2 chk("mtc0_epc_discard", EPC, 32'h0000_6000);
    mtc0(5'd15, 32'hDEAD_BEEF);
    A1 = 5'd15;
    #2 chk("prid_ro", DOut, 32'h0000_4D49);

    // PC - 4 wraps
    idle(); HWInt = 6'd0; EXLClr = 1'b1;
    cycle();
    idle(); HWInt = 6'b000001; PC = 32'h0000_0000; BD = 1'b1;
    cycle();
    #2 chk("epc_wrap", EPC, 32'hFFFF_FFFC);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      HWInt     = 6'($urandom);
      ExcCodeIn = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      WE        = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0:       A2 = 5'd12;
        1:       A2 = 5'd13;
        2:       A2 = 5'd14;
        3:       A2 = 5'd15;
        default: A2 = 5'($urandom);
      endcase
      DIn    = $urandom;
      PC     = $urandom & 32'hFFFF_FFFC;
      BD     = 1'($urandom);
      EXLClr = ($urandom_range(0, 4) == 0);
      A1     = 5'($urandom_range(10, 16));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
